// File: rtl/sweep_counter_ctrl_if.sv
// Sweep counter control bus: run request, bounds, step strobe and status.
// The master drives requests and bounds; the slave (the counter) drives status.
interface sweep_counter_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic         stop;
  logic         tick;
  logic         mode;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic [3:0]   reps;
  logic [N-1:0] q;
  logic         dir;
  logic         busy;
  logic         sweep_end;
  logic         done;
  logic         err;

  modport master (
    output start, stop, tick, mode, lo, hi, reps,
    input  q, dir, busy, sweep_end, done, err
  );

  modport slave (
    input  start, stop, tick, mode, lo, hi, reps,
    output q, dir, busy, sweep_end, done, err
  );
endinterface

// File: rtl/sweep_counter_ctrl.sv
// Sweep counter controller: runs a counter between latched bounds as a
// sawtooth (up only) or triangle (up then down), for a fixed number of sweeps
// or continuously until stopped. All outputs are registered.
module sweep_counter_ctrl #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset,
  sweep_counter_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

  localparam logic [N-1:0] one = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  logic [N-1:0] q;
  logic         dir;
  logic         busy;
  logic         sweep_end;
  logic         done;
  logic         err;

  // Run parameters captured when a run is accepted; bus changes mid-run are ignored.
  logic         mode_r;
  logic [N-1:0] lo_r;
  logic [N-1:0] hi_r;
  logic [3:0]   reps_r;
  logic [3:0]   count;

  logic [3:0]   count_next;
  logic         last_sweep;

  // Sweep count after the sweep that is completing now; reps of 0 never matches.
  assign count_next = count + 4'd1;
  assign last_sweep = (reps_r != 4'd0) && (count_next == reps_r);

  // Controller state, counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      sweep_end <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mode_r    <= 1'b0;
      lo_r      <= '0;
      hi_r      <= '0;
      reps_r    <= '0;
      count     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every branch sees the
      // pre-edge values; the pulse outputs default low and are set only on the
      // edge that produces the event, giving exactly one-cycle pulses.
      sweep_end <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;

      if (busy && bus.stop) begin
        // Abort wins over any step: counter holds, no completion reported.
        state <= IDLE;
        busy  <= 1'b0;
        dir   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (bus.lo < bus.hi) begin
                mode_r <= bus.mode;
                lo_r   <= bus.lo;
                hi_r   <= bus.hi;
                reps_r <= bus.reps;
                count  <= '0;
                state  <= LOAD;
                busy   <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end

          LOAD: begin
            q     <= lo_r;
            state <= UP;
            dir   <= 1'b1;
          end

          UP: begin
            if (bus.tick) begin
              if (q != hi_r) begin
                q <= q + one;
              end else if (mode_r) begin
                q     <= hi_r - one;
                state <= DOWN;
                dir   <= 1'b0;
              end else begin
                sweep_end <= 1'b1;
                count     <= count_next;
                if (last_sweep) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  dir   <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  q <= lo_r;
                end
              end
            end
          end

          DOWN: begin
            if (bus.tick) begin
              if (q != lo_r) begin
                q <= q - one;
              end else begin
                sweep_end <= 1'b1;
                count     <= count_next;
                if (last_sweep) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  q     <= lo_r + one;
                  state <= UP;
                  dir   <= 1'b1;
                end
              end
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            dir   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.q         = q;
  assign bus.dir       = dir;
  assign bus.busy      = busy;
  assign bus.sweep_end = sweep_end;
  assign bus.done      = done;
  assign bus.err       = err;

endmodule
